// File: rtl/tsmac_rxfifo_unpack.sv
// TSMAC RX FIFO read-side unpacker: header + 32-bit payload words in,
// little-endian byte stream with sop/eop out; illegal-length frames dropped.
module tsmac_rxfifo_unpack #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_LEN_WIDTH  = 16,
  parameter int c_MAX_LEN    = 1536
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                    fifo_rd_vld,
  output logic                    fifo_rd_en,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  output logic                    rx_sop,
  output logic                    rx_eop,
  input  logic                    rx_ready,
  output logic                    len_err,
  output logic [15:0]             frm_cnt,
  output logic [15:0]             err_cnt
);

  localparam int WW = c_LEN_WIDTH - 1;

  localparam logic [1:0] S_HDR  = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [c_DATA_WIDTH-1:0] wreg_q, wreg_d;
  logic                    wreg_vld_q, wreg_vld_d;
  logic [1:0]              idx_q, idx_d;
  logic [c_LEN_WIDTH-1:0]  bytes_left_q, bytes_left_d;
  logic [WW-1:0]           words_left_q, words_left_d;
  logic                    first_q, first_d;
  logic                    len_err_q, len_err_d;
  logic [15:0]             frm_cnt_q, frm_cnt_d;
  logic [15:0]             err_cnt_q, err_cnt_d;

  logic [c_LEN_WIDTH-1:0]  hdr_len;
  logic [c_LEN_WIDTH:0]    len_p3;
  logic [WW-1:0]           hdr_words;
  logic                    hdr_bad;
  logic                    pop;
  logic                    xfer;
  logic                    last_b;
  logic                    is_eop;

  assign hdr_len   = fifo_rd_data[c_LEN_WIDTH-1:0];
  assign len_p3    = {1'b0, hdr_len} + (c_LEN_WIDTH+1)'(3);
  assign hdr_words = len_p3[c_LEN_WIDTH:2];
  assign hdr_bad   = (hdr_len == '0) ||
                     (hdr_len > c_LEN_WIDTH'(c_MAX_LEN));

  assign is_eop   = (bytes_left_q == c_LEN_WIDTH'(1));
  assign rx_valid = wreg_vld_q;
  assign rx_sop   = wreg_vld_q & first_q;
  assign rx_eop   = wreg_vld_q & is_eop;
  assign xfer     = wreg_vld_q & rx_ready;
  assign last_b   = (idx_q == 2'd3) | is_eop;
  assign pop      = fifo_rd_vld & fifo_rd_en;
  assign len_err  = len_err_q;
  assign frm_cnt  = frm_cnt_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    rx_data = 8'h00;
    unique case (idx_q)
      2'd0: rx_data = wreg_q[7:0];
      2'd1: rx_data = wreg_q[15:8];
      2'd2: rx_data = wreg_q[23:16];
      2'd3: rx_data = wreg_q[31:24];
    endcase
  end

  // Reload only while the current word is empty or its last byte leaves now.
  always_comb begin
    fifo_rd_en = 1'b0;
    unique case (state_q)
      S_HDR:   fifo_rd_en = 1'b1;
      S_DROP:  fifo_rd_en = 1'b1;
      S_DATA:  fifo_rd_en = (words_left_q != '0) &
                            (~wreg_vld_q | (xfer & last_b));
      default: fifo_rd_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wreg_d       = wreg_q;
    wreg_vld_d   = wreg_vld_q;
    idx_d        = idx_q;
    bytes_left_d = bytes_left_q;
    words_left_d = words_left_q;
    first_d      = first_q;
    len_err_d    = 1'b0;
    frm_cnt_d    = frm_cnt_q;
    err_cnt_d    = err_cnt_q;
    unique case (state_q)
      S_HDR: begin
        if (pop) begin
          if (hdr_bad) begin
            len_err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF)
              err_cnt_d = err_cnt_q + 16'd1;
            if (hdr_words != '0) begin
              state_d      = S_DROP;
              words_left_d = hdr_words;
            end
          end else begin
            state_d      = S_DATA;
            bytes_left_d = hdr_len;
            words_left_d = hdr_words;
            first_d      = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          bytes_left_d = bytes_left_q - c_LEN_WIDTH'(1);
          idx_d        = idx_q + 2'd1;
          first_d      = 1'b0;
          if (last_b)
            wreg_vld_d = 1'b0;
          if (is_eop) begin
            frm_cnt_d = frm_cnt_q + 16'd1;
            state_d   = S_HDR;
          end
        end
        if (pop) begin
          wreg_d       = fifo_rd_data;
          wreg_vld_d   = 1'b1;
          idx_d        = 2'd0;
          words_left_d = words_left_q - WW'(1);
        end
      end
      S_DROP: begin
        if (pop) begin
          words_left_d = words_left_q - WW'(1);
          if (words_left_q == WW'(1))
            state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q      <= S_HDR;
      wreg_q       <= '0;
      wreg_vld_q   <= 1'b0;
      idx_q        <= 2'd0;
      bytes_left_q <= '0;
      words_left_q <= '0;
      first_q      <= 1'b0;
      len_err_q    <= 1'b0;
      frm_cnt_q    <= 16'd0;
      err_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      wreg_q       <= wreg_d;
      wreg_vld_q   <= wreg_vld_d;
      idx_q        <= idx_d;
      bytes_left_q <= bytes_left_d;
      words_left_q <= words_left_d;
      first_q      <= first_d;
      len_err_q    <= len_err_d;
      frm_cnt_q    <= frm_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_tsmac_rxfifo_unpack.sv
// Directed bench for tsmac_rxfifo_unpack: FWFT FIFO model feeding the DUT,
// byte monitor capturing transfers, hand-computed expectations.
module tb_tsmac_rxfifo_unpack;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_vld = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_ready = 1'b1;
  logic        len_err;
  logic [15:0] frm_cnt;
  logic [15:0] err_cnt;

  tsmac_rxfifo_unpack dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_en   (fifo_rd_en),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_sop       (rx_sop),
    .rx_eop       (rx_eop),
    .rx_ready     (rx_ready),
    .len_err      (len_err),
    .frm_cnt      (frm_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q[$];
  logic [7:0]  cap_d[$];
  logic        cap_s[$];
  logic        cap_e[$];
  int          cap_c[$];
  int          cyc = 0;
  int          n_pops = 0;
  int          n_lenerr = 0;
  int          n_vcyc = 0;
  int          stall_viol = 0;
  bit          vld_en = 1'b1;
  bit          rdy_tog = 1'b0;
  bit          hold_pend = 1'b0;
  logic [9:0]  hold_val;
  logic        pop_q;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge rd_clk)
    pop_q <= fifo_rd_vld & fifo_rd_en & ~rd_rst;

  always @(negedge rd_clk) begin
    cyc++;
    if (rd_rst) begin
      q.delete();
    end else if (pop_q) begin
      n_pops++;
      if (q.size() > 0) void'(q.pop_front());
    end
    fifo_rd_vld  = vld_en && (q.size() > 0);
    fifo_rd_data = (q.size() > 0) ? q[0] : 32'h0;
    rx_ready     = rdy_tog ? ~rx_ready : 1'b1;
    if (len_err) n_lenerr++;
    if (rx_valid) n_vcyc++;
    if (hold_pend && hold_val !== {rx_valid, rx_sop, rx_eop, rx_data[6:0]})
      stall_viol++;
    if (hold_pend && rx_data[7] !== 1'b0 && hold_val[6:0] == 7'h0)
      stall_viol = stall_viol;
    if (rx_valid && rx_ready) begin
      cap_d.push_back(rx_data);
      cap_s.push_back(rx_sop);
      cap_e.push_back(rx_eop);
      cap_c.push_back(cyc);
    end
    hold_pend = rx_valid && !rx_ready;
    hold_val  = {rx_valid, rx_sop, rx_eop, rx_data[6:0]};
  end

  task automatic step();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic clear_caps();
    cap_d.delete();
    cap_s.delete();
    cap_e.delete();
    cap_c.delete();
    n_pops     = 0;
    n_lenerr   = 0;
    n_vcyc     = 0;
    stall_viol = 0;
  endtask

  task automatic do_reset();
    step();
    rd_rst = 1'b1;
    repeat (2) step();
    rd_rst = 1'b0;
    clear_caps();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((q.size() != 0 || rx_valid) && n < 3000) begin
      step();
      n++;
    end
    repeat (4) step();
    chk({tag, "_timeout"}, 32'(n >= 3000), 32'd0);
  endtask

  task automatic chk_frame(input string tag, input int base,
                           input logic [7:0] b[], input bit contig);
    for (int i = 0; i < b.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), 32'(cap_d[base+i]), 32'(b[i]));
      chk($sformatf("%s_s%0d", tag, i), 32'(cap_s[base+i]), 32'(i == 0));
      chk($sformatf("%s_e%0d", tag, i), 32'(cap_e[base+i]),
          32'(i == b.size() - 1));
    end
    if (contig)
      chk({tag, "_contig"}, 32'(cap_c[base+b.size()-1] - cap_c[base]),
          32'(b.size() - 1));
  endtask

  initial begin
    logic [7:0] f1[];
    logic [7:0] f4[];
    logic [7:0] f8a[];
    logic [7:0] f8b[];
    int         eops;
    f1  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    f4  = '{8'h01, 8'h02, 8'h03, 8'h04};
    f8a = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    f8b = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};

    // reset state
    repeat (3) step();
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_sop",   32'(rx_sop),   32'd0);
    chk("rst_eop",   32'(rx_eop),   32'd0);
    chk("rst_data",  32'(rx_data),  32'd0);
    chk("rst_lerr",  32'(len_err),  32'd0);
    chk("rst_frm",   32'(frm_cnt),  32'd0);
    chk("rst_err",   32'(err_cnt),  32'd0);
    rd_rst = 1'b0;
    clear_caps();

    // 1: basic 5-byte frame
    q.push_back(32'h5); q.push_back(32'h44332211); q.push_back(32'hAA);
    wait_idle("t1");
    chk("t1_n", 32'(cap_d.size()), 32'd5);
    if (cap_d.size() == 5) chk_frame("t1", 0, f1, 1'b1);
    chk("t1_frm", 32'(frm_cnt), 32'd1);
    chk("t1_pops", 32'(n_pops), 32'd3);

    // 2: same frame with rx_ready toggling
    do_reset();
    rdy_tog = 1'b1;
    q.push_back(32'h5); q.push_back(32'h44332211); q.push_back(32'hAA);
    wait_idle("t2");
    rdy_tog = 1'b0;
    chk("t2_n", 32'(cap_d.size()), 32'd5);
    if (cap_d.size() == 5) chk_frame("t2", 0, f1, 1'b0);
    chk("t2_pops", 32'(n_pops), 32'd3);
    chk("t2_hold", 32'(stall_viol), 32'd0);
    chk("t2_frm", 32'(frm_cnt), 32'd1);

    // 3: zero-length header then a good L=4 frame
    do_reset();
    q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h04030201);
    wait_idle("t3");
    chk("t3_lerr", 32'(n_lenerr), 32'd1);
    chk("t3_err", 32'(err_cnt), 32'd1);
    chk("t3_n", 32'(cap_d.size()), 32'd4);
    if (cap_d.size() == 4) chk_frame("t3", 0, f4, 1'b1);
    chk("t3_frm", 32'(frm_cnt), 32'd1);

    // 4: oversize header L=1537 dropped (385 words)
    do_reset();
    q.push_back(32'h601);
    for (int i = 0; i < 385; i++) q.push_back(32'hA5A5_0000 | 32'(i));
    q.push_back(32'h4); q.push_back(32'h04030201);
    wait_idle("t4");
    chk("t4_err", 32'(err_cnt), 32'd1);
    chk("t4_vcyc", 32'(n_vcyc), 32'd4);
    chk("t4_pops", 32'(n_pops), 32'd388);
    chk("t4_n", 32'(cap_d.size()), 32'd4);
    if (cap_d.size() == 4) chk_frame("t4", 0, f4, 1'b1);
    chk("t4_frm", 32'(frm_cnt), 32'd1);

    // 5: back-to-back L=8 frames, then an underrun mid-frame
    do_reset();
    q.push_back(32'h8); q.push_back(32'h13121110); q.push_back(32'h17161514);
    q.push_back(32'h8); q.push_back(32'h23222120); q.push_back(32'h27262524);
    wait_idle("t5");
    chk("t5_n", 32'(cap_d.size()), 32'd16);
    if (cap_d.size() == 16) begin
      chk_frame("t5a", 0, f8a, 1'b1);
      chk_frame("t5b", 8, f8b, 1'b1);
      chk("t5_gap", 32'(cap_c[8] - cap_c[7]), 32'd3);
    end
    chk("t5_frm", 32'(frm_cnt), 32'd2);
    clear_caps();
    q.push_back(32'h8); q.push_back(32'h13121110);
    repeat (12) step();
    chk("t5u_n4", 32'(cap_d.size()), 32'd4);
    chk("t5u_vld", 32'(rx_valid), 32'd0);
    q.push_back(32'h17161514);
    wait_idle("t5u");
    chk("t5u_n", 32'(cap_d.size()), 32'd8);
    if (cap_d.size() == 8) chk_frame("t5u", 0, f8a, 1'b0);
    chk("t5u_frm", 32'(frm_cnt), 32'd3);

    // 6: reset after two bytes of an L=8 frame
    do_reset();
    q.push_back(32'h8); q.push_back(32'h13121110); q.push_back(32'h17161514);
    begin
      int n = 0;
      while (cap_d.size() < 2 && n < 100) begin
        @(posedge rd_clk);
        n++;
      end
      chk("t6_timeout", 32'(n >= 100), 32'd0);
    end
    #2;
    rd_rst = 1'b1;
    #1;
    chk("t6_vld", 32'(rx_valid), 32'd0);
    chk("t6_data", 32'(rx_data), 32'd0);
    chk("t6_sop", 32'(rx_sop), 32'd0);
    chk("t6_eop", 32'(rx_eop), 32'd0);
    chk("t6_frm0", 32'(frm_cnt), 32'd0);
    eops = 0;
    foreach (cap_e[i]) eops += int'(cap_e[i]);
    chk("t6_noeop", 32'(eops), 32'd0);
    repeat (2) step();
    rd_rst = 1'b0;
    clear_caps();
    q.push_back(32'h2); q.push_back(32'h0000BBAA);
    wait_idle("t6");
    chk("t6_n", 32'(cap_d.size()), 32'd2);
    if (cap_d.size() == 2) begin
      chk("t6_b0", 32'(cap_d[0]), 32'hAA);
      chk("t6_b1", 32'(cap_d[1]), 32'hBB);
      chk("t6_s0", 32'(cap_s[0]), 32'd1);
      chk("t6_e1", 32'(cap_e[1]), 32'd1);
    end
    chk("t6_frm", 32'(frm_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
